// File: rtl/alu_decode_stage.sv
// Registered, handshaked ALU decoder with architectural NZCV flag register
// and a saturating counter of accepted undefined encodings.
module alu_decode_stage #(
    parameter int          ALUCTRL_W   = 3,
    parameter int          UNDEF_CNT_W = 8,
    parameter logic [3:0]  FLAGS_RST   = 4'b0000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   alu_op,
    input  logic [4:0]             funct,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   flush,
    output logic [ALUCTRL_W-1:0]   alu_control,
    output logic [1:0]             flag_w,
    output logic                   no_write,
    output logic                   undef,
    input  logic                   ex_flag_we,
    input  logic [1:0]             ex_flag_w,
    input  logic                   ex_cond_ex,
    input  logic [3:0]             ex_alu_flags,
    output logic [3:0]             flags,
    output logic [UNDEF_CNT_W-1:0] undef_cnt
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ORR  = 3'b011;
    localparam logic [2:0] OP_EOR  = 3'b100;
    localparam logic [2:0] OP_RSB  = 3'b101;
    localparam logic [2:0] OP_MOVB = 3'b110;
    localparam logic [UNDEF_CNT_W-1:0] CNT_MAX = {UNDEF_CNT_W{1'b1}};

    // Returns {alu_control[2:0], flag_w[1:0], no_write, undef}
    function automatic logic [6:0] decode_fn(input logic aop, input logic [4:0] f);
        logic [2:0] ctrl;
        logic [1:0] fw;
        logic       nw;
        logic       ud;
        logic       s;
        s    = f[0];
        ctrl = OP_ADD;
        fw   = 2'b00;
        nw   = 1'b0;
        ud   = 1'b0;
        if (aop) begin
            case (f[4:1])
                4'b0100: begin ctrl = OP_ADD;  fw = s ? 2'b11 : 2'b00; end
                4'b0010: begin ctrl = OP_SUB;  fw = s ? 2'b11 : 2'b00; end
                4'b0011: begin ctrl = OP_RSB;  fw = s ? 2'b11 : 2'b00; end
                4'b0000: begin ctrl = OP_AND;  fw = s ? 2'b10 : 2'b00; end
                4'b1100: begin ctrl = OP_ORR;  fw = s ? 2'b10 : 2'b00; end
                4'b0001: begin ctrl = OP_EOR;  fw = s ? 2'b10 : 2'b00; end
                4'b1101: begin ctrl = OP_MOVB; fw = s ? 2'b10 : 2'b00; end
                // Compare/test forms only exist with S set; S=0 falls to undefined
                4'b1010: begin
                    nw = 1'b1;
                    if (s) begin ctrl = OP_SUB; fw = 2'b11; end
                    else   begin ud = 1'b1; end
                end
                4'b1011: begin
                    nw = 1'b1;
                    if (s) begin ctrl = OP_ADD; fw = 2'b11; end
                    else   begin ud = 1'b1; end
                end
                4'b1000: begin
                    nw = 1'b1;
                    if (s) begin ctrl = OP_AND; fw = 2'b10; end
                    else   begin ud = 1'b1; end
                end
                default: begin ud = 1'b1; nw = 1'b1; end
            endcase
        end else begin
            ctrl = OP_ADD;
        end
        return {ctrl, fw, nw, ud};
    endfunction

    logic                   out_valid_r;
    logic [ALUCTRL_W-1:0]   alu_control_r;
    logic [1:0]             flag_w_r;
    logic                   no_write_r;
    logic                   undef_r;
    logic [3:0]             flags_r;
    logic [UNDEF_CNT_W-1:0] undef_cnt_r;
    logic                   in_ready_s;
    logic                   accept_s;
    logic [6:0]             dec_s;

    assign in_ready_s = ~out_valid_r | out_ready;
    assign accept_s   = in_valid & in_ready_s;
    assign dec_s      = decode_fn(alu_op, funct);

    // Output stage register: flush beats accept, result held under backpressure
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r   <= 1'b0;
            alu_control_r <= '0;
            flag_w_r      <= 2'b00;
            no_write_r    <= 1'b0;
            undef_r       <= 1'b0;
        end else if (flush) begin
            out_valid_r   <= 1'b0;
        end else if (accept_s) begin
            out_valid_r   <= 1'b1;
            alu_control_r <= ALUCTRL_W'(dec_s[6:4]);
            flag_w_r      <= dec_s[3:2];
            no_write_r    <= dec_s[1];
            undef_r       <= dec_s[0];
        end else if (out_ready) begin
            out_valid_r   <= 1'b0;
        end
    end

    // Saturating count of accepted (not flushed) undefined decodes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            undef_cnt_r <= '0;
        end else if (accept_s && !flush && dec_s[0] && (undef_cnt_r != CNT_MAX)) begin
            undef_cnt_r <= undef_cnt_r + UNDEF_CNT_W'(1);
        end
    end

    // Architectural NZCV, written per half when Execute commits a flag update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_r <= FLAGS_RST;
        end else if (ex_flag_we && ex_cond_ex) begin
            if (ex_flag_w[1]) flags_r[3:2] <= ex_alu_flags[3:2];
            if (ex_flag_w[0]) flags_r[1:0] <= ex_alu_flags[1:0];
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign alu_control = alu_control_r;
    assign flag_w      = flag_w_r;
    assign no_write    = no_write_r;
    assign undef       = undef_r;
    assign flags       = flags_r;
    assign undef_cnt   = undef_cnt_r;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed scenarios plus random traffic checked
// against a table-driven reference model of the decode stage.
module tb_alu_decode_stage;

    localparam int         CW    = 4;
    localparam int         NW    = 2;
    localparam logic [3:0] FRST  = 4'b0110;

    logic          clk = 1'b0;
    logic          reset_n, in_valid, in_ready, alu_op, out_valid, out_ready, flush;
    logic [4:0]    funct;
    logic [CW-1:0] alu_control;
    logic [1:0]    flag_w, ex_flag_w;
    logic          no_write, undef, ex_flag_we, ex_cond_ex;
    logic [3:0]    ex_alu_flags, flags;
    logic [NW-1:0] undef_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         tbl_op [16];
    int         tbl_kind [16];
    logic       m_valid;
    logic [3:0] m_ctrl;
    logic [1:0] m_fw;
    logic       m_nw, m_ud;
    logic [3:0] m_flags;
    int         m_cnt;

    alu_decode_stage #(.ALUCTRL_W(CW), .UNDEF_CNT_W(NW), .FLAGS_RST(FRST)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .alu_control(alu_control), .flag_w(flag_w), .no_write(no_write),
        .undef(undef), .ex_flag_we(ex_flag_we), .ex_flag_w(ex_flag_w),
        .ex_cond_ex(ex_cond_ex), .ex_alu_flags(ex_alu_flags), .flags(flags),
        .undef_cnt(undef_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 undefined, 1 arithmetic, 2 logical, 3 compare (needs S), 4 test (needs S)
    task automatic ref_decode(input logic aop, input logic [4:0] f,
                              output logic [3:0] c, output logic [1:0] fw,
                              output logic nw, output logic ud);
        int k;
        logic s;
        c = 4'd0; fw = 2'b00; nw = 1'b0; ud = 1'b0;
        if (aop) begin
            k = tbl_kind[f[4:1]];
            s = f[0];
            if (k == 0 || ((k == 3 || k == 4) && !s)) begin
                ud = 1'b1; nw = 1'b1;
            end else begin
                c  = 4'(tbl_op[f[4:1]]);
                nw = (k >= 3);
                if (s) fw = (k == 1 || k == 3) ? 2'b11 : 2'b10;
            end
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_ctrl = 4'd0; m_fw = 2'b00; m_nw = 1'b0; m_ud = 1'b0;
        m_flags = FRST; m_cnt = 0;
    endtask

    task automatic cycle(input string tag);
        logic acc;
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'((!m_valid) | out_ready));
        acc = in_valid & (!m_valid | out_ready);
        @(posedge clk);
        #1;
        if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            ref_decode(alu_op, funct, m_ctrl, m_fw, m_nw, m_ud);
            m_valid = 1'b1;
            if (m_ud && m_cnt < 3) m_cnt++;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (ex_flag_we && ex_cond_ex) begin
            if (ex_flag_w[1]) m_flags[3:2] = ex_alu_flags[3:2];
            if (ex_flag_w[0]) m_flags[1:0] = ex_alu_flags[1:0];
        end
        chk({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, " flags"}, 32'(flags), 32'(m_flags));
        chk({tag, " undef_cnt"}, 32'(undef_cnt), 32'(m_cnt));
        if (m_valid) begin
            chk({tag, " alu_control"}, 32'(alu_control), 32'(m_ctrl));
            chk({tag, " flag_w"}, 32'(flag_w), 32'(m_fw));
            chk({tag, " no_write"}, 32'(no_write), 32'(m_nw));
            chk({tag, " undef"}, 32'(undef), 32'(m_ud));
        end
    endtask

    task automatic drive(input logic v, input logic aop, input logic [4:0] f,
                         input logic ordy, input logic fl);
        in_valid = v; alu_op = aop; funct = f; out_ready = ordy; flush = fl;
    endtask

    task automatic flag_drive(input logic we, input logic ce, input logic [1:0] fw,
                              input logic [3:0] af);
        ex_flag_we = we; ex_cond_ex = ce; ex_flag_w = fw; ex_alu_flags = af;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " alu_control"}, 32'(alu_control), 32'd0);
        chk({tag, " flag_w"}, 32'(flag_w), 32'd0);
        chk({tag, " no_write"}, 32'(no_write), 32'd0);
        chk({tag, " undef"}, 32'(undef), 32'd0);
        chk({tag, " flags"}, 32'(flags), 32'(FRST));
        chk({tag, " undef_cnt"}, 32'(undef_cnt), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin tbl_op[i] = 0; tbl_kind[i] = 0; end
        tbl_op[4'b0100] = 0; tbl_kind[4'b0100] = 1;
        tbl_op[4'b0010] = 1; tbl_kind[4'b0010] = 1;
        tbl_op[4'b0011] = 5; tbl_kind[4'b0011] = 1;
        tbl_op[4'b0000] = 2; tbl_kind[4'b0000] = 2;
        tbl_op[4'b1100] = 3; tbl_kind[4'b1100] = 2;
        tbl_op[4'b0001] = 4; tbl_kind[4'b0001] = 2;
        tbl_op[4'b1101] = 6; tbl_kind[4'b1101] = 2;
        tbl_op[4'b1010] = 1; tbl_kind[4'b1010] = 3;
        tbl_op[4'b1011] = 0; tbl_kind[4'b1011] = 3;
        tbl_op[4'b1000] = 2; tbl_kind[4'b1000] = 4;

        // Power-on reset
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        flag_drive(1'b0, 1'b0, 2'b00, 4'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        chk("por in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;

        // Full decode sweep, back-to-back
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, i[5], i[4:0], 1'b1, 1'b0);
            cycle("sweep");
        end
        drive(1'b1, 1'b1, 5'b10101, 1'b1, 1'b0);
        cycle("cmp_example");
        chk("cmp_example ctrl", 32'(alu_control), 32'h1);
        chk("cmp_example fw", 32'(flag_w), 32'h3);
        chk("cmp_example nw", 32'(no_write), 32'h1);

        // Reset while a result is pending and flags/counter are non-reset
        flag_drive(1'b1, 1'b1, 2'b11, 4'b1001);
        drive(1'b1, 1'b1, 5'b11110, 1'b0, 1'b0);
        cycle("pre_reset");
        flag_drive(1'b0, 1'b0, 2'b00, 4'd0);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        cycle("post_reset");

        // Backpressure: result held, no acceptance, then same-cycle accept on release
        drive(1'b1, 1'b1, 5'b01001, 1'b0, 1'b0);
        cycle("bp_accept");
        chk("bp ctrl", 32'(alu_control), 32'h0);
        chk("bp fw", 32'(flag_w), 32'h3);
        drive(1'b1, 1'b1, 5'b00101, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            chk("bp_hold in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold fw", 32'(flag_w), 32'h3);
        end
        drive(1'b1, 1'b1, 5'b00101, 1'b1, 1'b0);
        #1;
        chk("bp_release in_ready", 32'(in_ready), 32'd1);
        cycle("bp_release");
        chk("bp_release ctrl", 32'(alu_control), 32'h1);

        // Flush beats a same-cycle undefined accept
        drive(1'b1, 1'b1, 5'b11110, 1'b1, 1'b1);
        cycle("flush");
        chk("flush cnt", 32'(undef_cnt), 32'd0);
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        cycle("flush_idle");

        // Flag register
        flag_drive(1'b1, 1'b1, 2'b11, 4'b0000);
        cycle("flag_clear");
        flag_drive(1'b1, 1'b1, 2'b10, 4'b1111);
        cycle("flag_nz");
        chk("flag_nz value", 32'(flags), 32'hc);
        flag_drive(1'b1, 1'b0, 2'b11, 4'b0000);
        cycle("flag_condfail");
        flag_drive(1'b1, 1'b1, 2'b01, 4'b0011);
        drive(1'b1, 1'b1, 5'b01000, 1'b1, 1'b1);
        cycle("flag_cv_flush");
        chk("flag_cv value", 32'(flags), 32'hf);
        flag_drive(1'b0, 1'b1, 2'b11, 4'b0000);
        cycle("flag_nowe");

        // Counter saturation
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b1, 5'b11110, 1'b1, 1'b0);
            cycle("sat");
            chk("sat cnt", 32'(undef_cnt), 32'((i > 3) ? 3 : i));
        end

        // Random traffic after a fresh reset
        reset_n = 1'b0;
        #1;
        model_reset();
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3) != 0), 1'($urandom), 5'($urandom),
                  ($urandom_range(9) < 7), ($urandom_range(9) == 0));
            flag_drive(1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
